// File: rtl/freq_pkg.sv
// Shared types and constants for the frequency meter measurement stage.
package freq_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Gate select codes: full, /10 and /100 gate length (code 3 aliases /100).
    localparam logic [1:0] RANGE_X1   = 2'd0;
    localparam logic [1:0] RANGE_X10  = 2'd1;
    localparam logic [1:0] RANGE_X100 = 2'd2;

endpackage

// File: rtl/bcd_digit.sv
// One decade of the edge counter: counts 0..9, wraps and reports a carry.
module bcd_digit
    import freq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    input  logic hold,
    output bcd_t value,
    output logic carry_out
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && !hold) begin
            value <= (value == BCD_MAX) ? '0 : value + 4'd1;
        end
    end

    assign carry_out = (value == BCD_MAX) & inc;

endmodule

// File: rtl/freq_meter_core.sv
// Gate-window edge counter: counts sig_in rising edges in four BCD decades and
// latches the result, overflow flag and range once per window.
module freq_meter_core
    import freq_pkg::*;
#(
    parameter int GATE_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sig_in,
    input  logic [1:0] range,
    output bcd_t       th,
    output bcd_t       hun,
    output bcd_t       ten,
    output bcd_t       one,
    output logic       ovf,
    output logic       valid,
    output logic [1:0] range_q
);

    localparam int CW = $clog2(GATE_CYCLES);
    localparam logic [CW-1:0] G0_M1 = CW'(GATE_CYCLES - 1);
    localparam logic [CW-1:0] G1_M1 = CW'(GATE_CYCLES / 10 - 1);
    localparam logic [CW-1:0] G2_M1 = CW'(GATE_CYCLES / 100 - 1);

    logic          sync_p0, sync_p1, sync_p2;
    logic          sig_rise;
    state_t        state_q, state_d;
    logic [CW-1:0] gate_cnt;
    logic [CW-1:0] gate_load;
    logic [1:0]    range_w;
    logic          ovf_w;
    logic          clr_dig, count_en, latch_en;
    logic [3:0]    inc, carry;
    logic          sat;
    bcd_t          dig [4];

    // Stage boundary: two-flop synchronizer plus one delay flop for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= sig_in;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign sig_rise = sync_p1 & ~sync_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= CLEAR;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        clr_dig  = 1'b0;
        count_en = 1'b0;
        latch_en = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_dig = 1'b1;
                state_d = GATE;
            end
            GATE: begin
                count_en = 1'b1;
                if (gate_cnt == '0) state_d = LATCH;
            end
            LATCH: begin
                latch_en = 1'b1;
                state_d  = CLEAR;
            end
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        case (range)
            RANGE_X1:  gate_load = G0_M1;
            RANGE_X10: gate_load = G1_M1;
            default:   gate_load = G2_M1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt <= '0;
            range_w  <= '0;
        end else if (state_q == CLEAR) begin
            gate_cnt <= gate_load;
            range_w  <= range;
        end else if (state_q == GATE && gate_cnt != '0) begin
            gate_cnt <= gate_cnt - CW'(1);
        end
    end

    // Carry out of the top decade is exactly "all four digits at 9 and an edge".
    assign inc[0] = count_en & sig_rise;
    assign inc[1] = carry[0];
    assign inc[2] = carry[1];
    assign inc[3] = carry[2];
    assign sat    = carry[3];

    for (genvar i = 0; i < 4; i++) begin : g_digit
        bcd_digit u_digit (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (clr_dig),
            .inc      (inc[i]),
            .hold     (sat),
            .value    (dig[i]),
            .carry_out(carry[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ovf_w <= 1'b0;
        else if (clr_dig) ovf_w <= 1'b0;
        else if (sat)     ovf_w <= 1'b1;
    end

    // Stage boundary: display registers, held stable between valid pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            th      <= '0;
            hun     <= '0;
            ten     <= '0;
            one     <= '0;
            ovf     <= 1'b0;
            range_q <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= latch_en;
            if (latch_en) begin
                th      <= dig[3];
                hun     <= dig[2];
                ten     <= dig[1];
                one     <= dig[0];
                ovf     <= ovf_w;
                range_q <= range_w;
            end
        end
    end

endmodule

// File: tb/tb_freq_meter_core.sv
// Directed bench for freq_meter_core: window timing, BCD carry, range handling,
// overflow saturation and asynchronous reset.
module tb_freq_meter_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a_n, sig_a, ovf_a, valid_a;
    logic [1:0] range_a, range_q_a;
    logic [3:0] th_a, hun_a, ten_a, one_a;
    logic       rst_b_n, sig_b, ovf_b, valid_b;
    logic [1:0] range_b, range_q_b;
    logic [3:0] th_b, hun_b, ten_b, one_b;
    logic [15:0] disp_a, disp_b;

    assign disp_a = {th_a, hun_a, ten_a, one_a};
    assign disp_b = {th_b, hun_b, ten_b, one_b};

    int n_assert = 0;
    int n_fail   = 0;

    // G = 5000 / 500 / 50 for range 0 / 1 / 2
    freq_meter_core #(.GATE_CYCLES(5000)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .sig_in(sig_a), .range(range_a),
        .th(th_a), .hun(hun_a), .ten(ten_a), .one(one_a),
        .ovf(ovf_a), .valid(valid_a), .range_q(range_q_a)
    );

    // Long gate so that a period-4 input can exceed 9999 edges
    freq_meter_core #(.GATE_CYCLES(40400)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .sig_in(sig_b), .range(range_b),
        .th(th_b), .hun(hun_b), .ten(ten_b), .one(one_b),
        .ovf(ovf_b), .valid(valid_b), .range_q(range_q_b)
    );

    task automatic wait_valid_a(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid_a === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_valid_b(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid_b === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic pulses_a(input int cnt);
        repeat (cnt) begin
            sig_a = 1'b1;
            repeat (2) @(negedge clk);
            sig_a = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        sig_a = 1'b0; sig_b = 1'b0;
        range_a = 2'd2; range_b = 2'd0;
        repeat (3) @(negedge clk);
        n_assert++;
        if (disp_a !== 16'h0000) begin n_fail++; $display("FAIL reset_disp_a: got %h expected 0000", disp_a); end
        n_assert++;
        if ({ovf_a, valid_a, range_q_a} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctrl_a: got %b expected 0000", {ovf_a, valid_a, range_q_a}); end
        n_assert++;
        if ({disp_b, ovf_b, valid_b} !== 18'h0) begin n_fail++; $display("FAIL reset_b: got %h expected 0", {disp_b, ovf_b, valid_b}); end
    endtask

    task automatic test_first_valid;
        int n;
        rst_a_n = 1'b1;
        wait_valid_a(200, n);
        n_assert++;
        if (n !== 52) begin n_fail++; $display("FAIL first_valid_latency: got %0d expected 52", n); end
        n_assert++;
        if ({disp_a, ovf_a, range_q_a} !== {16'h0000, 1'b0, 2'd2}) begin n_fail++; $display("FAIL first_valid_out: got %h/%b/%0d expected 0000/0/2", disp_a, ovf_a, range_q_a); end
    endtask

    task automatic test_count_basic;
        int n;
        int pat_tab [3] = '{7, 10, 0};
        logic [15:0] exp_tab [3] = '{16'h0007, 16'h0010, 16'h0000};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_assert++;
            if (valid_a !== 1'b0) begin n_fail++; $display("FAIL valid_width[%0d]: got %b expected 0", i, valid_a); end
            pulses_a(pat_tab[i]);
            wait_valid_a(100, n);
            n_assert++;
            if (disp_a !== exp_tab[i]) begin n_fail++; $display("FAIL basic_count[%0d]: got %h expected %h (wait %0d)", i, disp_a, exp_tab[i], n); end
        end
    endtask

    task automatic test_range1;
        int n;
        range_a = 2'd1;
        pulses_a(25);
        wait_valid_a(600, n);
        n_assert++;
        if (n !== 402) begin n_fail++; $display("FAIL range1_period: got %0d expected 402", n); end
        n_assert++;
        if ({disp_a, range_q_a} !== {16'h0025, 2'd1}) begin n_fail++; $display("FAIL range1_out: got %h/%0d expected 0025/1", disp_a, range_q_a); end
    endtask

    task automatic test_range_change;
        int n;
        pulses_a(2);
        repeat (2) @(negedge clk);
        range_a = 2'd2;
        wait_valid_a(600, n);
        n_assert++;
        if (n !== 492) begin n_fail++; $display("FAIL range_change_old_gate: got %0d expected 492", n); end
        n_assert++;
        if ({disp_a, range_q_a} !== {16'h0002, 2'd1}) begin n_fail++; $display("FAIL range_change_old_out: got %h/%0d expected 0002/1", disp_a, range_q_a); end
        wait_valid_a(600, n);
        n_assert++;
        if (n !== 52) begin n_fail++; $display("FAIL range_change_new_gate: got %0d expected 52", n); end
        n_assert++;
        if ({disp_a, range_q_a} !== {16'h0000, 2'd2}) begin n_fail++; $display("FAIL range_change_new_out: got %h/%0d expected 0000/2", disp_a, range_q_a); end
    endtask

    task automatic test_carry;
        int n;
        range_a = 2'd0;
        pulses_a(1099);
        wait_valid_a(6000, n);
        n_assert++;
        if (n !== 606) begin n_fail++; $display("FAIL carry_period: got %0d expected 606", n); end
        n_assert++;
        if ({disp_a, ovf_a, range_q_a} !== {16'h1099, 1'b0, 2'd0}) begin n_fail++; $display("FAIL carry_1099: got %h/%b/%0d expected 1099/0/0", disp_a, ovf_a, range_q_a); end
        pulses_a(1100);
        wait_valid_a(6000, n);
        n_assert++;
        if (disp_a !== 16'h1100) begin n_fail++; $display("FAIL carry_1100: got %h expected 1100 (wait %0d)", disp_a, n); end
    endtask

    task automatic test_reset_mid;
        int n;
        range_a = 2'd1;
        pulses_a(3);
        wait_valid_a(600, n);
        n_assert++;
        if ({disp_a, range_q_a} !== {16'h0003, 2'd1}) begin n_fail++; $display("FAIL pre_reset_out: got %h/%0d expected 0003/1", disp_a, range_q_a); end
        pulses_a(5);
        rst_a_n = 1'b0;
        #1;
        n_assert++;
        if ({disp_a, ovf_a, valid_a, range_q_a} !== 20'h0) begin n_fail++; $display("FAIL async_reset_out: got %h expected 0", {disp_a, ovf_a, valid_a, range_q_a}); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_assert++;
            if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_no_valid[%0d]: got %b expected 0", i, valid_a); end
        end
        rst_a_n = 1'b1;
        wait_valid_a(600, n);
        n_assert++;
        if (n !== 502) begin n_fail++; $display("FAIL reset_release_latency: got %0d expected 502", n); end
        n_assert++;
        if ({disp_a, range_q_a} !== {16'h0000, 2'd1}) begin n_fail++; $display("FAIL reset_release_out: got %h/%0d expected 0000/1", disp_a, range_q_a); end
    endtask

    task automatic test_overflow;
        int n;
        n = -1;
        rst_b_n = 1'b1;
        for (int k = 1; k <= 41000; k++) begin
            sig_b = ((k % 4) == 1) || ((k % 4) == 2);
            @(posedge clk);
            @(negedge clk);
            if (valid_b === 1'b1) begin
                n = k;
                break;
            end
        end
        n_assert++;
        if (n !== 40402) begin n_fail++; $display("FAIL ovf_period: got %0d expected 40402", n); end
        n_assert++;
        if ({disp_b, ovf_b, range_q_b} !== {16'h9999, 1'b1, 2'd0}) begin n_fail++; $display("FAIL ovf_saturate: got %h/%b/%0d expected 9999/1/0", disp_b, ovf_b, range_q_b); end
        sig_b = 1'b0;
        range_b = 2'd1;
        @(negedge clk);
        n_assert++;
        if ({valid_b, disp_b} !== {1'b0, 16'h9999}) begin n_fail++; $display("FAIL ovf_hold: got %b/%h expected 0/9999", valid_b, disp_b); end
        wait_valid_b(5000, n);
        n_assert++;
        if (n !== 4041) begin n_fail++; $display("FAIL ovf_clear_period: got %0d expected 4041", n); end
        n_assert++;
        if ({disp_b, ovf_b, range_q_b} !== {16'h0000, 1'b0, 2'd1}) begin n_fail++; $display("FAIL ovf_clear: got %h/%b/%0d expected 0000/0/1", disp_b, ovf_b, range_q_b); end
    endtask

    initial begin
        test_reset;
        test_first_valid;
        test_count_basic;
        test_range1;
        test_range_change;
        test_carry;
        test_reset_mid;
        test_overflow;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_meter_core.md
# freq_meter_core

Measurement stage of the frequency meter. It counts rising edges of an external test signal during a fixed gate window derived from the system clock, in four cascaded BCD digits. At the end of each window it latches the result onto `th`/`hun`/`ten`/`one`, which feed the 7-segment scan decoder directly downstream. It also flags overflow and emits a one-cycle update strobe.

## Interface
- `GATE_CYCLES`, default 50_000_000: gate length in `clk` cycles at range 0 (1 s at 50 MHz). Must be divisible by 100 and ≥ 100.
- `clk` input 1: system clock; all state on rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `sig_in` input 1: signal under test; asynchronous to `clk`; frequency < `clk`/4.
- `range` input 2: gate select. 0 = `GATE_CYCLES`, 1 = `GATE_CYCLES`/10, 2 = `GATE_CYCLES`/100, 3 = same as 2. Sampled only in CLEAR.
- `th`, `hun`, `ten`, `one` output 4 each: latched BCD result, 0–9 each.
- `ovf` output 1: latched; last window exceeded 9999 edges.
- `valid` output 1: one-cycle pulse when the outputs update.
- `range_q` output 2: range in force for the currently displayed result, used for decimal-point placement.

## Operation
- Input path: 2-flop synchronizer on `sig_in`, then a third flop. An edge is `s2 & ~s3`, one cycle wide.
- FSM states are CLEAR, GATE and LATCH.
- CLEAR (1 cycle):
  - Zero the four BCD digits and the internal overflow flag.
  - Load the gate counter with `G-1`, where G follows `range`.
  - Capture `range` into the working range register.
  - Next state is GATE.
- GATE (G cycles):
  - Each edge increments digit `one`.
  - A digit at 9 wraps to 0 and carries into the next digit. The carry ripples combinationally within the same cycle.
  - If the count is 9999 and an edge arrives, the count holds at 9999 and the internal `ovf` is set (sticky).
  - The gate counter decrements each cycle. When it reaches 0, next state is LATCH.
  - An edge in the last GATE cycle is counted.
- LATCH (1 cycle):
  - Copy the digits, internal ovf and working range to `th`/`hun`/`ten`/`one`/`ovf`/`range_q`.
  - Pulse `valid`.
  - Next state is CLEAR.
- Edges detected during LATCH or CLEAR are discarded by design. This 2-cycle dead time is accepted.
- A `range` change mid-window has no effect until the next CLEAR. It is never applied to a window in progress.
- Reset (asynchronous, any state):
  - FSM goes to CLEAR.
  - Synchronizer flops, digits, gate counter, `th`/`hun`/`ten`/`one` and `range_q` go to 0; `ovf` and `valid` go to 0.
  - An in-progress window is abandoned with no `valid`.
- The displayed values are stable between `valid` pulses. The downstream decoder may sample them on any `clk_scan` edge without a handshake.

## Timing
- Measurement period is G+2 cycles (CLEAR + G × GATE + LATCH).
- First `valid` after reset release: at cycle G+2, counting the first post-reset edge as cycle 1.
- `sig_in` rise to counted edge: 3 `clk` cycles (2 sync + detect). Edges within 3 cycles of gate close fall into the dead time or the next window.
- Outputs change only on the `clk` edge ending LATCH, the same edge on which `valid` rises. `valid` is high for exactly 1 cycle.
- The gate counter is `$clog2(GATE_CYCLES)` bits. G values are constants computed from the parameter; there is no run-time divider.

## Structure
- Package `freq_pkg` holds:
  - the state encoding (CLEAR=2'd0, GATE=2'd1, LATCH=2'd2);
  - the BCD digit type (4 bits);
  - the constant `BCD_MAX` = 4'd9;
  - the range codes.
- Sub-module `bcd_digit` is instantiated four times. It contains one BCD digit with `inc`, `clr`, `carry_out` (value==9 & inc) and `hold` (saturation). Saturation is decided at the top as all-digits-9 & edge.
- Synchronizer, gate counter and FSM live in the top module.

## Test plan
- Use `GATE_CYCLES`=1000, range 0, with `sig_in` of period 10 `clk`, phase-aligned after reset. Required: first `valid` shows 0,1,0,0 (or 0,0,9,9 depending on phase), `ovf`=0, then a repeatable value every 1002 cycles.
- Set range 1 with period 4 (G=100). Required: 25 or 24 counted, `range_q`=1.
- Overflow: `GATE_CYCLES`=100000, range 0, period 4. Required: 9,9,9,9 with `ovf`=1. The next window with `sig_in` held low gives 0,0,0,0 with `ovf`=0.
- Carry ripple: inject exactly 1099 single-cycle-separated edges (period 4) into a G=5000 window. Required: 1,0,9,9. Then 1100 edges gives 1,1,0,0.
- Change `range` 0→2 mid-GATE. Required: the current window completes at the old G with `range_q` unchanged, and the following window uses G/100.
- Assert `rst_n` low mid-GATE for 3 cycles. Required: all outputs 0 asynchronously, no `valid`, and the next `valid` comes G+2 cycles after release.
